// File: rtl/commit_marker_queue.sv
// commit_marker_queue: decodes SLTI-x0 phase markers on the commit lanes,
// timestamps them and queues them in program order for the event logger.
module commit_marker_queue #(
  parameter int LANES = 2,
  parameter int DEPTH = 8,
  parameter int CYC_W = 32,
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [LANES-1:0]      commit_valid,
  input  logic [32*LANES-1:0]   commit_inst,
  output logic                  evt_valid,
  input  logic                  evt_ready,
  output logic [2:0]            evt_phase,
  output logic                  evt_is_end,
  output logic [LW-1:0]         evt_lane,
  output logic [CYC_W-1:0]      evt_time,
  output logic                  evt_seq_err,
  output logic                  seq_err,
  output logic                  overflow,
  output logic [7:0]            drop_cnt,
  output logic [6:0]            open_mask
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [2:0]       phase;
    logic             is_end;
    logic [LW-1:0]    lane;
    logic [CYC_W-1:0] ts;
    logic             serr;
  } ent_t;

  ent_t             mem_q [DEPTH];
  ent_t             mem_d [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [6:0]       open_q, open_d;
  logic             serr_q, serr_d;
  logic             ovf_q, ovf_d;
  logic [7:0]       drop_q, drop_d;

  logic             pop;
  logic [CW-1:0]    free;
  logic [CW-1:0]    npush;
  logic [31:0]      inst;
  logic [3:0]       code;
  logic             hit;
  logic             err;
  ent_t             head;

  // Decode lanes oldest-first, track pairing, push or drop each marker.
  always_comb begin
    mem_d  = mem_q;
    open_d = open_q;
    serr_d = serr_q;
    ovf_d  = ovf_q;
    drop_d = drop_q;
    inst   = '0;
    code   = '0;
    hit    = 1'b0;
    err    = 1'b0;
    pop    = valid_q & evt_ready;
    free   = CW'(DEPTH) - cnt_q + CW'(pop);
    npush  = '0;
    for (int i = 0; i < LANES; i++) begin
      inst = commit_inst[32*i +: 32];
      code = inst[23:20];
      hit  = commit_valid[i]
          && (inst[31:24] == 8'h00)
          && (inst[19:0] == 20'h02013)
          && (code <= 4'd13);
      err  = 1'b0;
      if (hit) begin
        err = code[0] ? !open_d[code[3:1]]
                      : open_d[code[3:1]];
        open_d[code[3:1]] = !code[0];
        if (err) serr_d = 1'b1;
        if (npush < free) begin
          mem_d[wr_q + AW'(npush)] = '{
            phase:  code[3:1],
            is_end: code[0],
            lane:   LW'(i),
            ts:     cyc_q,
            serr:   err
          };
          npush = npush + CW'(1);
        end else begin
          ovf_d = 1'b1;
          if (drop_d != 8'hff) drop_d = drop_d + 8'd1;
        end
      end
    end
    cnt_d   = cnt_q + npush - CW'(pop);
    wr_d    = wr_q + AW'(npush);
    rd_d    = rd_q + AW'(pop);
    cyc_d   = cyc_q + CYC_W'(1);
    valid_d = (cnt_d != '0);
  end

  // Control state with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      cyc_q   <= '0;
      open_q  <= '0;
      serr_q  <= 1'b0;
      ovf_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      cyc_q   <= cyc_d;
      open_q  <= open_d;
      serr_q  <= serr_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
    end
  end

  // Entry storage; stale contents are hidden by the valid mask.
  always_ff @(posedge clock) begin
    if (reset) begin
      mem_q <= mem_d;
    end
  end

  assign head        = mem_q[rd_q];
  assign evt_valid   = valid_q;
  assign evt_phase   = valid_q ? head.phase  : '0;
  assign evt_is_end  = valid_q ? head.is_end : 1'b0;
  assign evt_lane    = valid_q ? head.lane   : '0;
  assign evt_time    = valid_q ? head.ts     : '0;
  assign evt_seq_err = valid_q ? head.serr   : 1'b0;
  assign seq_err     = serr_q;
  assign overflow    = ovf_q;
  assign drop_cnt    = drop_q;
  assign open_mask   = open_q;

endmodule

// File: tb/tb_commit_marker_queue.sv
// tb_commit_marker_queue: directed checks of marker decode, ordering,
// pairing errors, overflow/drop accounting and mid-run reset.
module tb_commit_marker_queue;

  logic        clock;
  logic        reset;
  logic [1:0]  commit_valid;
  logic [63:0] commit_inst;
  logic        evt_valid;
  logic        evt_ready;
  logic [2:0]  evt_phase;
  logic        evt_is_end;
  logic [0:0]  evt_lane;
  logic [31:0] evt_time;
  logic        evt_seq_err;
  logic        seq_err;
  logic        overflow;
  logic [7:0]  drop_cnt;
  logic [6:0]  open_mask;

  int total = 0;
  int bad = 0;
  int n;

  commit_marker_queue #(
    .LANES(2), .DEPTH(8), .CYC_W(32)
  ) dut (
    .clock(clock),
    .reset(reset),
    .commit_valid(commit_valid),
    .commit_inst(commit_inst),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_phase(evt_phase),
    .evt_is_end(evt_is_end),
    .evt_lane(evt_lane),
    .evt_time(evt_time),
    .evt_seq_err(evt_seq_err),
    .seq_err(seq_err),
    .overflow(overflow),
    .drop_cnt(drop_cnt),
    .open_mask(open_mask)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc1(input logic [1:0] v,
                      input logic [31:0] i0,
                      input logic [31:0] i1);
    commit_valid = v;
    commit_inst  = {i1, i0};
    tick();
    commit_valid = 2'b00;
    commit_inst  = '0;
  endtask

  initial begin
    reset        = 1'b0;
    commit_valid = 2'b00;
    commit_inst  = '0;
    evt_ready    = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    // interval with cyc=0
    chk("rst_valid", evt_valid, 0);
    chk("rst_phase", evt_phase, 0);
    chk("rst_time", evt_time, 0);
    chk("rst_open", open_mask, 0);
    chk("rst_serr", seq_err, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_drop", drop_cnt, 0);

    // single INIT start at cyc=5
    repeat (5) tick();
    cyc1(2'b01, 32'h00802013, 32'h0);
    chk("s_valid", evt_valid, 1);
    chk("s_phase", evt_phase, 4);
    chk("s_end", evt_is_end, 0);
    chk("s_lane", evt_lane, 0);
    chk("s_time", evt_time, 5);
    chk("s_open", open_mask, 7'b0010000);
    tick();
    chk("s_hold_v", evt_valid, 1);
    chk("s_hold_t", evt_time, 5);
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    chk("s_empty", evt_valid, 0);

    // dual lane TRAIN start/end at cyc=8
    cyc1(2'b11, 32'h00c02013, 32'h00d02013);
    chk("d0_phase", evt_phase, 6);
    chk("d0_end", evt_is_end, 0);
    chk("d0_lane", evt_lane, 0);
    chk("d0_time", evt_time, 8);
    chk("d0_serr", evt_seq_err, 0);
    chk("d_open", open_mask, 7'b0010000);
    evt_ready = 1'b1;
    tick();
    chk("d1_valid", evt_valid, 1);
    chk("d1_phase", evt_phase, 6);
    chk("d1_end", evt_is_end, 1);
    chk("d1_lane", evt_lane, 1);
    chk("d1_time", evt_time, 8);
    chk("d1_serr", evt_seq_err, 0);
    tick();
    evt_ready = 1'b0;
    chk("d_empty", evt_valid, 0);
    chk("d_gserr", seq_err, 0);

    // END DELAY with DELAY closed
    cyc1(2'b01, 32'h00302013, 32'h0);
    chk("e_phase", evt_phase, 1);
    chk("e_end", evt_is_end, 1);
    chk("e_eserr", evt_seq_err, 1);
    chk("e_gserr", seq_err, 1);
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    cyc1(2'b01, 32'h00202013, 32'h0);
    chk("e2_eserr", evt_seq_err, 0);
    chk("e2_gserr", seq_err, 1);
    evt_ready = 1'b1;
    cyc1(2'b01, 32'h00202013, 32'h0);
    evt_ready = 1'b0;
    chk("e3_valid", evt_valid, 1);
    chk("e3_phase", evt_phase, 1);
    chk("e3_end", evt_is_end, 0);
    chk("e3_eserr", evt_seq_err, 1);
    chk("e3_open", open_mask, 7'b0010010);
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    chk("e_empty", evt_valid, 0);

    // non-markers
    cyc1(2'b11, 32'h00e02013, 32'h00002093);
    cyc1(2'b01, 32'h01002013, 32'h0);
    cyc1(2'b00, 32'h00802013, 32'h00902013);
    chk("n_valid", evt_valid, 0);
    chk("n_open", open_mask, 7'b0010010);
    chk("n_drop", drop_cnt, 0);

    // overflow: 10 BIM markers into 8 slots
    repeat (5) cyc1(2'b11, 32'h00a02013, 32'h00b02013);
    chk("o_valid", evt_valid, 1);
    chk("o_drop", drop_cnt, 2);
    chk("o_ovf", overflow, 1);
    chk("o_open", open_mask, 7'b0010010);
    chk("o_phase", evt_phase, 5);
    chk("o_lane", evt_lane, 0);
    evt_ready = 1'b1;
    cyc1(2'b11, 32'h00a02013, 32'h00b02013);
    evt_ready = 1'b0;
    chk("of_drop", drop_cnt, 3);
    chk("of_end", evt_is_end, 1);
    chk("of_lane", evt_lane, 1);
    chk("of_eserr", evt_seq_err, 0);
    n = 0;
    evt_ready = 1'b1;
    while (evt_valid && n < 20) begin
      n++;
      tick();
    end
    evt_ready = 1'b0;
    chk("of_count", n, 8);
    chk("of_drop2", drop_cnt, 3);

    // reset mid-run with 3 queued
    cyc1(2'b11, 32'h00402013, 32'h00502013);
    cyc1(2'b01, 32'h00602013, 32'h0);
    chk("r_pre", evt_valid, 1);
    reset = 1'b0;
    cyc1(2'b01, 32'h00802013, 32'h0);
    reset = 1'b1;
    chk("r_valid", evt_valid, 0);
    chk("r_serr", seq_err, 0);
    chk("r_ovf", overflow, 0);
    chk("r_drop", drop_cnt, 0);
    chk("r_open", open_mask, 0);
    chk("r_time", evt_time, 0);
    cyc1(2'b01, 32'h00c02013, 32'h0);
    chk("r2_valid", evt_valid, 1);
    chk("r2_phase", evt_phase, 6);
    chk("r2_time", evt_time, 0);
    chk("r2_open", open_mask, 7'b1000000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/commit_marker_queue.md
# commit_marker_queue

Synthesizable front end for the simulation phase monitor. Watches the ROB commit lanes, detects the SLTI-x0 phase-marker instructions (INIT, TRAIN, BIM, DELAY, VCTM, TEXE, LEAK; start/end), timestamps them and serialises them in program order into a FIFO. The downstream event logger pops one event per cycle. Also flags start/end pairing errors and lost markers.

## Interface
- LANES, 2: commit lanes per cycle; lane 0 is oldest.
- DEPTH, 8: FIFO entries; power of two, at least 2.
- CYC_W, 32: timestamp/cycle-counter width.
- clock  in  1  clock.
- reset  in  1  reset, synchronous, active-low.
- commit_valid  in  LANES  per-lane commit valid.
- commit_inst  in  32*LANES  committed instruction; lane i at [32i+31:32i].
- evt_valid  out  1  FIFO head valid.
- evt_ready  in  1  consumer accepts head.
- evt_phase  out  3  0 VCTM, 1 DELAY, 2 TEXE, 3 LEAK, 4 INIT, 5 BIM, 6 TRAIN.
- evt_is_end  out  1  1 = END marker, 0 = START.
- evt_lane  out  log2(LANES) (min 1)  lane the marker committed on.
- evt_time  out  CYC_W  cycle count at commit.
- evt_seq_err  out  1  this event broke pairing.
- seq_err  out  1  sticky: any pairing error since reset.
- overflow  out  1  sticky: any marker dropped.
- drop_cnt  out  8  dropped markers, saturates at 255.
- open_mask  out  7  currently open phases, bit = phase.

## Operation
- Marker decode per lane: commit_valid[i] and inst[31:24]==0 and inst[19:0]==20'h02013 and code=inst[23:20] <= 13. phase=code[3:1], is_end=code[0]. Codes 14/15 and any other instruction are ignored.
- Cycle counter cyc: 0 in first cycle out of reset, +1 each cycle, wraps modulo 2^CYC_W. Captured evt_time = cyc of the commit cycle.
- Pairing: lanes evaluated in order 0..LANES-1, each lane sees updates from lower lanes in the same cycle. START on phase p: error if open_mask[p] already set, then set. END: error if open_mask[p] clear, then clear. Pairing applies to every decoded marker, dropped or not. Any error sets seq_err and the entry's evt_seq_err.
- Enqueue: decoded markers pushed in lane order. Free slots = DEPTH - count + (evt_valid & evt_ready). If markers exceed free slots, the lowest lanes fill them, the rest are dropped. Each drop sets overflow and increments drop_cnt (saturating).
- Dequeue: valid/ready. Pop when evt_valid & evt_ready. Outputs come from head entry and stay stable while evt_valid & !evt_ready.
- FIFO pointers wrap modulo DEPTH. count has width log2(DEPTH)+1.

## Timing
- Reset (reset==0 at a clock edge): count, pointers, cyc, open_mask, seq_err, overflow, drop_cnt cleared. evt_valid=0; evt_phase/evt_is_end/evt_lane/evt_time/evt_seq_err read 0. Commit inputs during reset are ignored. Reset mid-operation discards queued entries.
- Latency: marker committed in cycle t into an empty FIFO gives evt_valid=1 in t+1.
- Throughput: up to LANES pushes and 1 pop per cycle. Push and pop in the same cycle on a full FIFO accepts exactly one marker.
- open_mask, seq_err, overflow, drop_cnt update one cycle after the commit cycle.
- evt_valid is a registered function of count (count != 0). There is no combinational path from commit_* to evt_*.

## Test plan
- Single marker: reset, then lane0 commits 32'h00802013 at cyc=5 -> next cycle evt_valid=1, phase=4, is_end=0, lane=0, time=5; open_mask=7'b0010000.
- Dual lane order: same cycle, lane0=32'h00c02013 and lane1=32'h00d02013 -> two events in order, TRAIN start then TRAIN end, lanes 0 then 1, same time, no seq_err; open_mask ends at 0.
- Pairing error: END 32'h00302013 with DELAY not open -> evt_seq_err=1, seq_err=1 sticky. A later START 32'h00202013 twice -> second START also flagged.
- Overflow: evt_ready=0, DEPTH=8, 5 cycles of two markers each -> 8 queued, drop_cnt=2, overflow=1. With a full FIFO, evt_ready=1 and two markers in one cycle -> lane0 accepted, lane1 dropped, drop_cnt=3.
- Non-markers: 32'h00e02013, 32'h00002093 (rd=1), 32'h01002013, and commit_valid=0 carrying a marker -> no events, open_mask unchanged.
- Reset mid-run: 3 queued events, reset held low 1 cycle -> evt_valid=0, all sticky flags and counters 0, next commit timestamped from cyc restart at 0.
